spi_display_sink: RTL and testbench
===================================

Name: spi_display_sink

Overview:
- SPI display-link receiver: the far end of our bit-banged SPI display master.
- Oversamples the four display-link pins (cs_n, clock, dc, mosi) in the local clock domain.
- Deserialises MSB-first SPI mode 0 words and tags each word with its D/C level.
- Pushes word plus tag into a FIFO-style sink via a put/full handshake.
- Used as a display model in loopback benches and as a front end for on-chip display emulation.

Parameters:
W  8  word width in bits, >= 2; bit counter is clog2(W) bits wide

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
spi_cs_n  in  1  chip select, active low, asynchronous to clock
spi_clock  in  1  SPI clock, idle low (mode 0), asynchronous
spi_dc  in  1  data/command select (1 = data, 0 = command), asynchronous
spi_mosi  in  1  serial data, MSB first, asynchronous
out  out  W  received word
out_dc  out  1  spi_dc level captured with the last bit of the word
put  out  1  one-cycle strobe: out/out_dc valid, sink must accept
full  in  1  sink cannot accept a word this cycle
overrun  out  1  one-cycle strobe: completed word dropped because full was high
busy  out  1  synchronised chip select is active (frame in progress)

Behaviour:
- Reset (reset low, asynchronous):
  - out = 0, out_dc = 0, put = 0, overrun = 0, busy = 0.
  - Bit counter = 0, shift register = 0.
  - Synchroniser stages reset to idle pin levels: cs_n = 1, clock = 0, dc = 0, mosi = 0.
- Synchronisation:
  - Each pin passes through a 2-FF synchroniser.
  - A third register on the clock path holds the previous synchronised value.
  - sclk_rise = sync_clock & ~prev_clock.
- Timing requirement on the link: spi_clock high and low phases each >= 3 clock periods. Setup of mosi/dc to the spi_clock rise >= 1 clock period.
- States:
  - IDLE: synchronised cs_n = 1. Counter held at 0, sclk_rise ignored, busy = 0.
  - RECV: synchronised cs_n = 0, busy = 1.
  - IDLE -> RECV on synchronised cs_n falling. Counter cleared on entry.
  - RECV -> IDLE on synchronised cs_n rising. Partial word discarded, counter cleared, no put, no overrun.
- On each sclk_rise in RECV:
  - shift = {shift[W-2:0], sync_mosi}.
  - counter increments.
  - When counter == W-1, the word completes this cycle:
    - full = 0: register out = {shift[W-2:0], sync_mosi} and out_dc = sync_dc; put = 1 on the next cycle only.
    - full = 1: out and out_dc are unchanged, put stays 0, overrun = 1 for one cycle.
    - In both cases the counter wraps to 0.
- Multiple words per frame: back-to-back words within one cs_n low period are received continuously with no gap bits.
- out and out_dc hold their values until the next accepted word.
- Latency: put is high exactly 4 clock edges after the first clock edge that samples spi_clock high on the pin (2 sync + 1 edge detect + 1 output register).
- Simultaneous events:
  - sclk_rise in the same cycle as synchronised cs_n rising: the edge is ignored (cs_n has priority).
  - sclk_rise in the same cycle as synchronised cs_n falling: the edge is ignored, and the counter starts at 0.
- full is sampled only in the cycle the word completes. full at other times has no effect.
- put and overrun are never high in the same cycle.
- Reset mid-word: immediate return to reset state. The first frame after reset release receives cleanly from bit 0.

Test Plan:
1. Hold reset low with random pin activity -> out = 0, out_dc = 0, put = 0, overrun = 0, busy = 0 throughout; busy = 1 within 3 cycles after release with cs_n low.
2. Frame of W = 8, mosi bits 0xA5, dc = 0, full = 0, spi_clock half-period 4 cycles -> exactly one put pulse with out = 0xA5, out_dc = 0, 4 edges after the 8th spi_clock rise.
3. Single cs_n frame carrying 0x3C with dc = 1, then 0xFF with dc = 0 -> two put pulses in order: (0x3C, 1) then (0xFF, 0); no extra strobes.
4. cs_n raised after 5 bits of 0xF0, then a new frame 0x81 -> no put for the partial word; one put with out = 0x81.
5. full = 1 when 0x55 completes -> put stays 0, one overrun pulse, out keeps its previous value; next word 0x66 with full = 0 -> put with out = 0x66.
6. reset pulsed low after 3 bits of a word -> outputs clear immediately; after release, frame 0x12 with dc = 1 -> put with out = 0x12, out_dc = 1.

Source files
------------

// File: rtl/spi_display_sink_if.sv
// rtl/spi_display_sink_if.sv - display-link pins and word sink handshake
interface spi_display_sink_if #(
    parameter int W = 8
);
    logic         spi_cs_n;
    logic         spi_clock;
    logic         spi_dc;
    logic         spi_mosi;
    logic [W-1:0] out;
    logic         out_dc;
    logic         put;
    logic         full;
    logic         overrun;
    logic         busy;

    modport master (
        output spi_cs_n, spi_clock, spi_dc, spi_mosi, full,
        input  out, out_dc, put, overrun, busy
    );

    modport slave (
        input  spi_cs_n, spi_clock, spi_dc, spi_mosi, full,
        output out, out_dc, put, overrun, busy
    );
endinterface

// File: rtl/spi_display_sink.sv
// rtl/spi_display_sink.sv - oversampling SPI mode 0 display-link receiver
module spi_display_sink #(
    parameter int W = 8
) (
    input  logic                clock,
    input  logic                reset,
    spi_display_sink_if.slave   link
);
    localparam int CW = $clog2(W);

    typedef enum logic {IDLE, RECV} state_t;

    state_t        state, state_nx;
    logic          cs_s1, cs_s2;
    logic          clk_s1, clk_s2, clk_prev;
    logic          dc_s1, dc_s2;
    logic          mosi_s1, mosi_s2;
    logic          rise_q, rise_mosi, rise_dc;
    logic [CW-1:0] count;
    logic [W-1:0]  shift;
    logic [W-1:0]  out_q;
    logic          out_dc_q, put_q, overrun_q;
    logic          take, word_done;

    // Two-flop synchronisers, idling at the pin rest levels while in reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            clk_s1  <= 1'b0;
            clk_s2  <= 1'b0;
            dc_s1   <= 1'b0;
            dc_s2   <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            cs_s1   <= link.spi_cs_n;
            cs_s2   <= cs_s1;
            clk_s1  <= link.spi_clock;
            clk_s2  <= clk_s1;
            dc_s1   <= link.spi_dc;
            dc_s2   <= dc_s1;
            mosi_s1 <= link.spi_mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    // Registered rise detect; data and dc travel alongside so they line up with the pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_prev  <= 1'b0;
            rise_q    <= 1'b0;
            rise_mosi <= 1'b0;
            rise_dc   <= 1'b0;
        end else begin
            clk_prev  <= clk_s2;
            rise_q    <= clk_s2 & ~clk_prev;
            rise_mosi <= mosi_s2;
            rise_dc   <= dc_s2;
        end
    end

    // Frame state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Frame tracking; a clock rise only counts inside a frame that is not ending this cycle.
    always_comb begin
        state_nx = state;
        take     = 1'b0;
        case (state)
            IDLE: if (!cs_s2) state_nx = RECV;
            RECV: begin
                if (cs_s2) state_nx = IDLE;
                else       take = rise_q;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign word_done = take && (count == CW'(W - 1));

    // Shift in bits, hand completed words to the sink or flag the drop when it is full.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            shift     <= '0;
            out_q     <= '0;
            out_dc_q  <= 1'b0;
            put_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            put_q     <= 1'b0;
            overrun_q <= 1'b0;
            if (state == IDLE || cs_s2) begin
                count <= '0;
            end else if (take) begin
                shift <= {shift[W-2:0], rise_mosi};
                if (word_done) begin
                    count <= '0;
                    if (link.full) begin
                        overrun_q <= 1'b1;
                    end else begin
                        out_q    <= {shift[W-2:0], rise_mosi};
                        out_dc_q <= rise_dc;
                        put_q    <= 1'b1;
                    end
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

    assign link.out     = out_q;
    assign link.out_dc  = out_dc_q;
    assign link.put     = put_q;
    assign link.overrun = overrun_q;
    assign link.busy    = (state == RECV);
endmodule

// File: tb/tb_spi_display_sink.sv
// tb/tb_spi_display_sink.sv - scoreboard bench for spi_display_sink
module tb_spi_display_sink;
    logic clock = 1'b0;
    logic reset;

    spi_display_sink_if #(.W(8)) link();

    spi_display_sink #(.W(8)) dut (
        .clock (clock),
        .reset (reset),
        .link  (link)
    );

    always #5 clock = ~clock;

    int cycle = 0;
    always @(posedge clock) cycle <= cycle + 1;

    typedef struct {
        logic [7:0] word;
        logic       dc;
        int         at;
    } exp_t;

    exp_t sb[$];
    int   ovr_q[$];
    int   checks = 0;
    int   errors = 0;
    exp_t e;
    int   ov_at;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: every put/overrun must match the head of its expectation queue.
    always @(negedge clock) begin
        if (link.put === 1'b1 || link.overrun === 1'b1)
            chk("put_overrun_exclusive", {31'd0, link.put & link.overrun}, 0);
        if (link.put === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_put", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("out", {24'd0, link.out}, {24'd0, e.word});
                chk("out_dc", {31'd0, link.out_dc}, {31'd0, e.dc});
                chk("put_latency", cycle, e.at);
            end
        end
        if (link.overrun === 1'b1) begin
            if (ovr_q.size() == 0) begin
                chk("unexpected_overrun", 1, 0);
            end else begin
                ov_at = ovr_q.pop_front();
                chk("overrun_latency", cycle, ov_at);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // mode: 0 = no outcome expected, 1 = put expected, 2 = overrun expected
    task automatic send_word(input logic [7:0] w, input logic dc, input int nbits, input int mode);
        for (int i = 0; i < nbits; i++) begin
            link.spi_mosi = w[7-i];
            link.spi_dc   = dc;
            tick(4);
            link.spi_clock = 1'b1;
            if (i == 7) begin
                if (mode == 1)      sb.push_back('{w, dc, cycle + 4});
                else if (mode == 2) ovr_q.push_back(cycle + 4);
            end
            tick(4);
            link.spi_clock = 1'b0;
        end
    endtask

    task automatic frame_start();
        link.spi_cs_n = 1'b0;
        tick(4);
    endtask

    task automatic frame_end();
        tick(2);
        link.spi_cs_n = 1'b1;
        tick(6);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || ovr_q.size() != 0) && n < 40) begin
            tick(1);
            n++;
        end
        chk({tag, "_drained"}, sb.size() + ovr_q.size(), 0);
    endtask

    initial begin
        reset          = 1'b0;
        link.spi_cs_n  = 1'b1;
        link.spi_clock = 1'b0;
        link.spi_dc    = 1'b0;
        link.spi_mosi  = 1'b0;
        link.full      = 1'b0;

        // 1: reset holds outputs low under pin activity
        repeat (20) begin
            @(negedge clock);
            link.spi_cs_n  = 1'($urandom);
            link.spi_clock = 1'($urandom);
            link.spi_dc    = 1'($urandom);
            link.spi_mosi  = 1'($urandom);
            #1;
            chk("reset_outputs",
                {20'd0, link.out, link.out_dc, link.put, link.overrun, link.busy}, 0);
        end
        @(negedge clock);
        link.spi_clock = 1'b0;
        link.spi_dc    = 1'b0;
        link.spi_mosi  = 1'b0;
        link.spi_cs_n  = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(3);
        chk("busy_after_reset", {31'd0, link.busy}, 1);
        link.spi_cs_n = 1'b1;
        tick(6);
        chk("busy_idle", {31'd0, link.busy}, 0);

        // 2: single word
        frame_start();
        send_word(8'hA5, 1'b0, 8, 1);
        frame_end();
        drain("t2");

        // 3: two words in one frame
        frame_start();
        send_word(8'h3C, 1'b1, 8, 1);
        send_word(8'hFF, 1'b0, 8, 1);
        frame_end();
        drain("t3");

        // 4: partial word discarded on cs_n rise
        frame_start();
        send_word(8'hF0, 1'b0, 5, 0);
        frame_end();
        frame_start();
        send_word(8'h81, 1'b0, 8, 1);
        frame_end();
        drain("t4");

        // 5: full at completion gives overrun, then a normal word
        link.full = 1'b1;
        frame_start();
        send_word(8'h55, 1'b0, 8, 2);
        tick(2);
        chk("out_held", {24'd0, link.out}, 32'h81);
        link.full = 1'b0;
        send_word(8'h66, 1'b0, 8, 1);
        frame_end();
        drain("t5");

        // 6: reset mid-word, then clean frame
        frame_start();
        send_word(8'hE7, 1'b1, 3, 0);
        reset = 1'b0;
        #1;
        chk("midreset_out", {24'd0, link.out}, 0);
        chk("midreset_flags", {28'd0, link.out_dc, link.put, link.overrun, link.busy}, 0);
        tick(3);
        link.spi_cs_n = 1'b1;
        reset = 1'b1;
        tick(4);
        frame_start();
        send_word(8'h12, 1'b1, 8, 1);
        frame_end();
        drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
